// File: rtl/lp_output_stage.sv
// Output conditioning for the low-pass filter: shift/saturate the wide filter word
// to the DAC width, slew-limit the DAC word, and ramp it in/out with an enable FSM.
module lp_output_stage #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 14,
    parameter int SHW       = $clog2(2 * WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [2*WIDTH-1:0]     data_i,
    input  logic [SHW-1:0]         shift_i,
    input  logic [OUT_WIDTH-2:0]   step_i,
    input  logic                   enable_i,
    input  logic                   clr_i,
    output logic [OUT_WIDTH-1:0]   dac_o,
    output logic                   sat_o,
    output logic [15:0]            sat_cnt_o,
    output logic                   active_o
);

    localparam int DW = 2 * WIDTH;

    localparam logic signed [DW-1:0]        SAT_MAX_C = (DW)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [DW-1:0]        SAT_MIN_C = (DW)'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic signed [OUT_WIDTH-1:0] DAC_MAX_C = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] DAC_MIN_C = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [SHW:0]                SHIFT_LIM_C = (SHW+1)'(DW);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRACK     = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_e;

    state_e                       state_r;
    state_e                       state_s;

    logic signed [DW-1:0]         data_r;
    logic [SHW-1:0]               shift_r;
    logic [SHW-1:0]               shift_clamp_s;
    logic [SHW:0]                 shift_ext_s;

    logic signed [DW-1:0]         sh_s;
    logic signed [OUT_WIDTH-1:0]  target_s;
    logic                         sat_s;
    logic signed [OUT_WIDTH-1:0]  target_r;
    logic                         sat_r;

    logic signed [OUT_WIDTH-1:0]  goal_s;
    logic signed [OUT_WIDTH:0]    diff_s;
    logic [OUT_WIDTH:0]           abs_s;
    logic [OUT_WIDTH:0]           step_ext_s;
    logic [OUT_WIDTH:0]           dac_ext_s;
    logic [OUT_WIDTH:0]           dac_sum_s;
    logic signed [OUT_WIDTH-1:0]  dac_s;
    logic signed [OUT_WIDTH-1:0]  dac_r;

    logic [15:0]                  cnt_s;
    logic [15:0]                  cnt_r;

    // Clamp oversized shift requests to the largest meaningful shift.
    always_comb begin
        shift_ext_s = {1'b0, shift_i};
        if (shift_ext_s >= SHIFT_LIM_C) begin
            shift_clamp_s = SHW'(DW - 1);
        end else begin
            shift_clamp_s = shift_i;
        end
    end

    // Input register: sample and shift amount travel together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_r  <= '0;
            shift_r <= '0;
        end else begin
            data_r  <= $signed(data_i);
            shift_r <= shift_clamp_s;
        end
    end

    // Arithmetic shift followed by saturation to the signed DAC range.
    always_comb begin
        sh_s = data_r >>> shift_r;
        if (sh_s > SAT_MAX_C) begin
            target_s = DAC_MAX_C;
            sat_s    = 1'b1;
        end else if (sh_s < SAT_MIN_C) begin
            target_s = DAC_MIN_C;
            sat_s    = 1'b1;
        end else begin
            target_s = sh_s[OUT_WIDTH-1:0];
            sat_s    = 1'b0;
        end
    end

    // Target/saturation register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_r <= '0;
            sat_r    <= 1'b0;
        end else begin
            target_r <= target_s;
            sat_r    <= sat_s;
        end
    end

    // Slew limiter; the one-bit-wider difference keeps min-to-max moves from wrapping.
    always_comb begin
        if (state_r == ST_TRACK) begin
            goal_s = target_r;
        end else begin
            goal_s = '0;
        end
        dac_ext_s  = {dac_r[OUT_WIDTH-1], dac_r};
        diff_s     = $signed({goal_s[OUT_WIDTH-1], goal_s}) - $signed(dac_ext_s);
        step_ext_s = {2'b00, step_i};
        if (diff_s[OUT_WIDTH]) begin
            abs_s     = ~diff_s + (OUT_WIDTH+1)'(1);
            dac_sum_s = dac_ext_s - step_ext_s;
        end else begin
            abs_s     = diff_s;
            dac_sum_s = dac_ext_s + step_ext_s;
        end
        if (state_r == ST_IDLE) begin
            dac_s = '0;
        end else if ((step_i == '0) || (abs_s <= step_ext_s)) begin
            dac_s = goal_s;
        end else begin
            dac_s = dac_sum_s[OUT_WIDTH-1:0];
        end
    end

    // Enable FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    state_s = ST_TRACK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (!enable_i) begin
                    state_s = ST_RAMP_DOWN;
                end else begin
                    state_s = ST_TRACK;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable_i) begin
                    state_s = ST_TRACK;
                end else if (dac_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RAMP_DOWN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Saturation counter: clear wins, increments only while tracking, sticks at full scale.
    always_comb begin
        if (clr_i) begin
            cnt_s = 16'h0000;
        end else if (sat_r && (state_r == ST_TRACK) && (cnt_r != 16'hFFFF)) begin
            cnt_s = cnt_r + 16'h0001;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, DAC word and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            dac_r   <= '0;
            cnt_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            dac_r   <= dac_s;
            cnt_r   <= cnt_s;
        end
    end

    assign dac_o     = dac_r;
    assign sat_o     = sat_r;
    assign sat_cnt_o = cnt_r;
    assign active_o  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lp_output_stage.sv
// Directed bench for lp_output_stage: stimulus pushes cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_lp_output_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] data_i;
    logic [4:0]  shift_i;
    logic [12:0] step_i;
    logic        enable_i;
    logic        clr_i;
    logic [13:0] dac_o;
    logic        sat_o;
    logic [15:0] sat_cnt_o;
    logic        active_o;

    typedef struct {
        int cyc;
        int dac;
        int sat;
        int cnt;
        int act;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    lp_output_stage dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .data_i    (data_i),
        .shift_i   (shift_i),
        .step_i    (step_i),
        .enable_i  (enable_i),
        .clr_i     (clr_i),
        .dac_o     (dac_o),
        .sat_o     (sat_o),
        .sat_cnt_o (sat_cnt_o),
        .active_o  (active_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int c, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
        end
    endtask

    task automatic expect_at(input int d, input int dac, input int sat, input int cnt, input int act);
        exp_t e;
        e.cyc = cyc + d;
        e.dac = dac;
        e.sat = sat;
        e.cnt = cnt;
        e.act = act;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk_i) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                chk("dac",    cyc, int'($signed(dac_o)), exp_q[i].dac);
                chk("sat",    cyc, int'(sat_o),          exp_q[i].sat);
                chk("satcnt", cyc, int'(sat_cnt_o),      exp_q[i].cnt);
                chk("active", cyc, int'(active_o),       exp_q[i].act);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni   = 1'b0;
        data_i   = 32'd0;
        shift_i  = 5'd0;
        step_i   = 13'd0;
        enable_i = 1'b0;
        clr_i    = 1'b0;
        tick(2);

        // reset state, then idle after release
        expect_at(1, 0, 0, 0, 0);
        rst_ni = 1'b1;
        expect_at(2, 0, 0, 0, 0);
        expect_at(3, 0, 0, 0, 0);
        tick(3);

        // pass-through: 65536 >>> 4 = 4096
        step_i   = 13'd0;
        shift_i  = 5'd4;
        data_i   = 32'd65536;
        enable_i = 1'b1;
        expect_at(1, 0, 0, 0, 1);
        expect_at(2, 0, 0, 0, 1);
        expect_at(3, 4096, 0, 0, 1);
        tick(3);

        // positive saturation and counter
        data_i = 32'h7FFF0000;
        expect_at(2, 4096, 1, 0, 1);
        expect_at(3, 8191, 1, 1, 1);
        expect_at(4, 8191, 1, 2, 1);
        expect_at(5, 8191, 1, 3, 1);
        tick(5);
        clr_i = 1'b1;
        expect_at(1, 8191, 1, 0, 1);
        tick(1);
        clr_i = 1'b0;
        expect_at(1, 8191, 1, 1, 1);

        // negative saturation
        data_i  = 32'hFFFF0000;
        shift_i = 5'd0;
        expect_at(2, 8191, 1, 2, 1);
        expect_at(3, -8192, 1, 3, 1);
        tick(3);

        // back to zero target
        data_i = 32'd0;
        expect_at(3, 0, 0, 5, 1);
        tick(3);

        // slew up to 1000 with step 100
        step_i  = 13'd100;
        shift_i = 5'd4;
        data_i  = 32'd16000;
        expect_at(2, 0, 0, 5, 1);
        for (int i = 0; i < 10; i++) expect_at(3 + i, 100 * (i + 1), 0, 5, 1);
        expect_at(13, 1000, 0, 5, 1);
        tick(13);

        // ramp down to idle
        enable_i = 1'b0;
        expect_at(1, 1000, 0, 5, 1);
        for (int i = 0; i < 10; i++) expect_at(2 + i, 900 - 100 * i, 0, 5, 1);
        expect_at(12, 0, 0, 5, 0);
        tick(12);

        // rise, drop back to 500, re-enable without a jump
        enable_i = 1'b1;
        expect_at(1, 0, 0, 5, 1);
        for (int j = 1; j <= 5; j++) expect_at(1 + j, 100 * j, 0, 5, 1);
        expect_at(7, 600, 0, 5, 1);
        expect_at(8, 500, 0, 5, 1);
        for (int j = 1; j <= 5; j++) expect_at(8 + j, 500 + 100 * j, 0, 5, 1);
        expect_at(14, 1000, 0, 5, 1);
        tick(6);
        enable_i = 1'b0;
        tick(1);
        enable_i = 1'b1;
        tick(7);

        // reset in the middle of a ramp-down
        enable_i = 1'b0;
        expect_at(1, 1000, 0, 5, 1);
        expect_at(2, 900, 0, 5, 1);
        expect_at(3, 800, 0, 5, 1);
        tick(3);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        expect_at(0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        expect_at(1, 0, 0, 0, 0);
        expect_at(2, 0, 0, 0, 0);
        tick(3);

        foreach (exp_q[i]) begin
            total++;
            bad++;
            $display("FAIL unchecked cyc=%0d got=pending want=compared", exp_q[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
